iot_event_tx: RTL and testbench
===============================

# iot_event_tx

Transmit side of the active-device monitor interface. The block watches N per-device activity levels and turns every net connect or disconnect into a single-cycle `change` pulse, with `on_off` giving the direction: 1 = connect, 0 = disconnect. Events are serialised at most one per clock, with round-robin fairness. The block sits between the device status lines and the `monitor` counter, and drives its `change`/`on_off` inputs directly. It keeps its own mirror count, which must always equal the monitor's `counter_out`.

## Interface
Parameters:
- `N_DEV`, 8, number of device status lines; 2..64.
- `CNT_W`, 8, width of the mirror count; N_DEV ≤ 2^CNT_W − 1.
- `ID_W`, $clog2(N_DEV), width of the device index (derived; do not override).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: one clock; asynchronous, active-high.
- `dev_active`  in  N_DEV  per-device activity level; synchronous to `clk`.
- `change`  out  1  one-cycle event strobe toward the monitor.
- `on_off`  out  1  event direction: 1 = connect, 0 = disconnect. Valid when `change`=1, otherwise 0.
- `dev_id`  out  ID_W  index of the device reported by the current event; 0 when idle.
- `pending`  out  N_DEV  devices whose level differs from the last reported level.
- `busy`  out  1  high when `pending` ≠ 0.
- `tracked_count`  out  CNT_W  number of devices reported active so far.

## Operation
- State registers:
  - `reported[N_DEV-1:0]`: last level sent for each device.
  - `ptr[ID_W-1:0]`: round-robin start index.
  - Registered outputs `change`, `on_off`, `dev_id`, `tracked_count`.
- Combinational: `diff = dev_active ^ reported`; `pending = diff`; `busy = |diff`.
- Each edge with diff ≠ 0:
  - Pick the first set bit of `diff`, searching upward from `ptr` with wrap.
  - Call it `i`. Register `change`=1, `on_off`=`dev_active[i]`, `dev_id`=i.
  - Set `reported[i]` = `dev_active[i]`.
  - Set `ptr` = (i+1) mod N_DEV.
  - Set `tracked_count` ±1, following `on_off`.
- Each edge with diff = 0: `change`=0, `on_off`=0, `dev_id`=0; `ptr` and `tracked_count` hold.
- Two-state FSM, derived from registered `change`:
  - IDLE (`change`=0) → EMIT whenever diff ≠ 0.
  - EMIT → EMIT while diff ≠ 0 after the update, else → IDLE.
  - Back-to-back events are allowed: `change` may stay high for consecutive cycles, one event per cycle.
- Net-change semantics:
  - A device that toggles and returns to its reported level before being serviced generates no event.
  - A device that toggles while its own event is being emitted is re-flagged in `diff` the next cycle.
- Count bounds: `tracked_count` always equals popcount(`reported`), so it cannot over- or underflow. Simulation assertion: no increment at N_DEV, no decrement at 0.
- Reset (async, any time, including mid-burst):
  - `reported`=0, `ptr`=0, `change`=0, `on_off`=0, `dev_id`=0, `tracked_count`=0.
  - After release, every device high in `dev_active` is re-reported as a connect, one per cycle, lowest index first.
  - This matches the monitor being reset to 0 by the same `rst`.

## Timing
- Latency: a `dev_active` change sampled at edge k produces `change` during cycle k→k+1. The monitor consumes it at edge k+1.
- Worst-case service delay for one device: N_DEV cycles after its change is first sampled.
- `pending` and `busy` are combinational from `dev_active` and `reported`. All other outputs are registered.
- Reset values: every output is 0, except `pending`/`busy`, which follow `dev_active` immediately (reported=0).

## Structure
- Shared package `iot_pkg`:
  - Default `N_DEV` and `CNT_W`.
  - Direction constants `EV_CONNECT`=1'b1 and `EV_DISCONNECT`=1'b0.
  - FSM state typedef {IDLE, EMIT}.
- Sub-module `rr_pick`:
  - Parameterised on N_DEV.
  - Inputs `req[N_DEV-1:0]` and `start[ID_W-1:0]`.
  - Outputs `grant_valid` and `grant_id`.
  - Purely combinational rotate-and-priority-encode.
- Top level: `reported`/`ptr`/counter registers plus output regs; target 150–250 lines total.

## Test plan
- Reset with `dev_active`=8'h00, release, hold 10 cycles → `change`=0, `tracked_count`=0, `busy`=0 throughout.
- Set `dev_active`=8'h05 → next two cycles emit (dev 0, on) then (dev 2, on); `tracked_count` goes 1 then 2; then `change`=0 and `ptr`=3.
- From 8'h05, set 8'h04 → one event (dev 0, off); `tracked_count`=1.
- Set 8'hFF from 8'h00 with `ptr`=3 → eight consecutive events with ids 3,4,5,6,7,0,1,2, all on; `tracked_count`=8; `change` high for exactly 8 cycles.
- Toggle dev 5 high then low while dev 1 is being serviced → no event for dev 5; `pending[5]` is seen high for one cycle only.
- Assert `rst` mid-burst, at the 4th of 8 events, with `dev_active`=8'hFF → outputs drop to 0 asynchronously. After release, 8 connect events run from id 0 and `tracked_count` ends at 8. The bench checks `monitor.counter_out` == `tracked_count` every cycle.

Source files
------------

// File: rtl/iot_event_tx_pkg.sv
// iot_pkg: shared definitions for the active-device monitor transmit side.
//   N_DEV_DEFAULT / CNT_W_DEFAULT : default device count and mirror-count width
//   EV_CONNECT / EV_DISCONNECT    : values carried on on_off with a change pulse
//   state_t                       : two-state emitter FSM {IDLE, EMIT}
package iot_pkg;

  localparam int N_DEV_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 8;

  localparam logic EV_CONNECT    = 1'b1;
  localparam logic EV_DISCONNECT = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/iot_event_tx_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req[N_DEV-1:0]   requesting devices
//   start[ID_W-1:0]  index that gets first priority (must be < N_DEV)
//   grant_valid      any request present
//   grant_id         first requesting index at or above start, with wrap
module rr_pick #(
  parameter int N_DEV = 8,
  parameter int ID_W  = $clog2(N_DEV)
) (
  input  logic [N_DEV-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  // Duplicating req and shifting by start rotates it so that bit k of the
  // low half is request (start + k) mod N_DEV, for any N_DEV.
  logic [2*N_DEV-1:0] doubled;
  logic [2*N_DEV-1:0] shifted;
  logic [N_DEV-1:0]   rotated;
  logic [ID_W:0]      sum;

  assign doubled = {req, req};
  assign shifted = doubled >> start;
  assign rotated = shifted[N_DEV-1:0];

  // NOTE: every output gets a default before the search loop so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    sum         = '0;
    // Descending scan: the last hit written is the lowest rotated offset.
    for (int k = N_DEV - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        grant_valid = 1'b1;
        sum         = {1'b0, start} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_DEV)) sum = sum - (ID_W+1)'(N_DEV);
        grant_id    = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/iot_event_tx.sv
// iot_event_tx: turns per-device activity level changes into a serial stream
// of single-cycle change/on_off events for the monitor counter, one per clock,
// round-robin fair, and keeps a mirror of the monitor's count.
//   clk, rst       clock (rising edge), async active-high reset
//   dev_active     per-device activity levels, synchronous to clk
//   change         one-cycle event strobe (registered)
//   on_off         event direction, 1 = connect, 0 = disconnect (registered)
//   dev_id         device index of the current event, 0 when idle (registered)
//   pending        devices whose level differs from the last reported level
//   busy           any device pending
//   tracked_count  number of devices reported active (registered)
module iot_event_tx
  import iot_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int ID_W  = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic [N_DEV-1:0] pending,
  output logic             busy,
  output logic [CNT_W-1:0] tracked_count
);

  logic [N_DEV-1:0] reported;
  logic [ID_W-1:0]  ptr;
  state_t           state;
  logic [N_DEV-1:0] diff;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             grant_level;

  assign diff        = dev_active ^ reported;
  assign pending     = diff;
  assign busy        = |diff;
  assign grant_level = dev_active[grant_id];

  rr_pick #(
    .N_DEV (N_DEV),
    .ID_W  (ID_W)
  ) u_pick (
    .req         (diff),
    .start       (ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // The FSM state is the registered event strobe itself: EMIT exactly in the
  // cycles where an event is being presented to the monitor.
  assign change = (state == EMIT);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      reported      <= '0;
      ptr           <= '0;
      on_off        <= 1'b0;
      dev_id        <= '0;
      tracked_count <= '0;
    end else if (grant_valid) begin
      state              <= EMIT;
      on_off             <= grant_level;
      dev_id             <= grant_id;
      reported[grant_id] <= grant_level;
      ptr                <= (grant_id == ID_W'(N_DEV - 1)) ? '0 : grant_id + 1'b1;
      // Reported level flips only on a real difference, so the count moves
      // in lockstep with popcount(reported).
      if (grant_level == EV_CONNECT) tracked_count <= tracked_count + CNT_W'(1);
      else                           tracked_count <= tracked_count - CNT_W'(1);
    end else begin
      state  <= IDLE;
      on_off <= EV_DISCONNECT;
      dev_id <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && grant_valid) begin
      assert (!(grant_level == EV_CONNECT && tracked_count == CNT_W'(N_DEV)))
        else $error("tracked_count increment at N_DEV");
      assert (!(grant_level == EV_DISCONNECT && tracked_count == '0))
        else $error("tracked_count decrement at 0");
    end
  end

endmodule

// File: tb/tb_iot_event_tx.sv
// tb_iot_event_tx: scenario bench for iot_event_tx with an event scoreboard
// and a behavioural monitor counter that consumes change/on_off.
module tb_iot_event_tx;

  localparam int N_DEV = 8;
  localparam int CNT_W = 8;
  localparam int ID_W  = 3;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic             on;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_DEV-1:0] dev_active = '0;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic [N_DEV-1:0] pending;
  logic             busy;
  logic [CNT_W-1:0] tracked_count;

  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];
  int  mon_count;

  iot_event_tx #(.N_DEV(N_DEV), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .dev_active    (dev_active),
    .change        (change),
    .on_off        (on_off),
    .dev_id        (dev_id),
    .pending       (pending),
    .busy          (busy),
    .tracked_count (tracked_count)
  );

  always #5 clk = ~clk;

  // Monitor counter: consumes an event on the edge after it is presented.
  always @(posedge clk or posedge rst) begin
    if (rst)         mon_count <= 0;
    else if (change) mon_count <= on_off ? mon_count + 1 : mon_count - 1;
  end

  // Mirror must equal the monitor once any in-flight event is applied.
  always @(negedge clk) begin
    int want;
    want = mon_count + (change ? (on_off ? 1 : -1) : 0);
    checks++;
    if (int'(tracked_count) !== want) begin
      errors++;
      $display("FAIL monitor_sync: tracked_count=%0d required=%0d", tracked_count, want);
    end
  end

  function automatic void push_ev(int id, bit on, int cnt);
    ev_t e;
    e.id  = ID_W'(id);
    e.on  = on;
    e.cnt = CNT_W'(cnt);
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    dev_active = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({change, on_off, dev_id, tracked_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required=0",
               {change, on_off, dev_id, tracked_count});
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (change !== 1'b0 || tracked_count !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: change=%b count=%0d busy=%b required 0/0/0",
                 change, tracked_count, busy);
      end
    end
  endtask

  task automatic test_connect_pair();
    int cyc = 0;
    ev_t e;
    dev_active = 8'h05;
    push_ev(0, 1'b1, 1);
    push_ev(2, 1'b1, 2);
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      e = sb.pop_front();
      checks++;
      if ({change, dev_id, on_off, tracked_count} !== {1'b1, e.id, e.on, e.cnt}) begin
        errors++;
        $display("FAIL pair_event: chg/id/on/cnt=%b/%0d/%b/%0d required 1/%0d/%b/%0d",
                 change, dev_id, on_off, tracked_count, e.id, e.on, e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0 || dut.ptr !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pair_after: change=%b ptr=%0d busy=%b required 0/3/0",
               change, dut.ptr, busy);
    end
  endtask

  task automatic test_disconnect();
    int cyc = 0;
    ev_t e;
    // 05 -> 04 disconnects dev 0, then 04 -> 00 disconnects dev 2 (ptr ends at 3).
    dev_active = 8'h04;
    push_ev(0, 1'b0, 1);
    @(negedge clk);
    dev_active = 8'h00;
    push_ev(2, 1'b0, 0);
    while (sb.size() != 0 && cyc < 20) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      e = sb.pop_front();
      checks++;
      if ({change, dev_id, on_off, tracked_count} !== {1'b1, e.id, e.on, e.cnt}) begin
        errors++;
        $display("FAIL disc_event: chg/id/on/cnt=%b/%0d/%b/%0d required 1/%0d/%b/%0d",
                 change, dev_id, on_off, tracked_count, e.id, e.on, e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0 || dut.ptr !== 3'd3 || tracked_count !== '0) begin
      errors++;
      $display("FAIL disc_after: change=%b ptr=%0d count=%0d required 0/3/0",
               change, dut.ptr, tracked_count);
    end
  endtask

  task automatic test_back_to_back(input logic [N_DEV-1:0] pattern, input bit on);
    int cyc = 0;
    ev_t e;
    dev_active = pattern;
    for (int k = 0; k < N_DEV; k++)
      push_ev((3 + k) % N_DEV, on, on ? k + 1 : N_DEV - 1 - k);
    while (sb.size() != 0 && cyc < 30) begin
      @(negedge clk); cyc++;
      e = sb.pop_front();
      checks++;
      if ({change, dev_id, on_off, tracked_count} !== {1'b1, e.id, e.on, e.cnt}) begin
        errors++;
        $display("FAIL burst_event: chg/id/on/cnt=%b/%0d/%b/%0d required 1/%0d/%b/%0d",
                 change, dev_id, on_off, tracked_count, e.id, e.on, e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: change=%b busy=%b required 0/0", change, busy);
    end
  endtask

  task automatic test_net_change();
    // dev 1 connects; while its event is presented dev 5 pulses between edges.
    dev_active = 8'h02;
    @(negedge clk);
    checks++;
    if ({change, dev_id, on_off, tracked_count} !== {1'b1, 3'd1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL net_dev1: chg/id/on/cnt=%b/%0d/%b/%0d required 1/1/1/1",
               change, dev_id, on_off, tracked_count);
    end
    dev_active = 8'h22;
    #1;
    checks++;
    if (pending !== 8'h20 || busy !== 1'b1) begin
      errors++;
      $display("FAIL net_pending_hi: pending=%h busy=%b required 20/1", pending, busy);
    end
    #1 dev_active = 8'h02;
    #1;
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL net_pending_lo: pending=%h required 00", pending);
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0 || tracked_count !== 8'd1) begin
      errors++;
      $display("FAIL net_no_event: change=%b count=%0d required 0/1", change, tracked_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    ev_t e;
    dev_active = 8'h00;          // dev 1 disconnects, ptr -> 2
    @(negedge clk);
    @(negedge clk);
    dev_active = 8'hFF;          // burst 2,3,4,5,... ; interrupted at the 4th
    for (int k = 0; k < 4; k++) push_ev(2 + k, 1'b1, k + 1);
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      e = sb.pop_front();
      checks++;
      if ({change, dev_id, on_off, tracked_count} !== {1'b1, e.id, e.on, e.cnt}) begin
        errors++;
        $display("FAIL mid_event: chg/id/on/cnt=%b/%0d/%b/%0d required 1/%0d/%b/%0d",
                 change, dev_id, on_off, tracked_count, e.id, e.on, e.cnt);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({change, on_off, dev_id, tracked_count} !== '0 || pending !== 8'hFF) begin
      errors++;
      $display("FAIL mid_async_reset: outputs=%h pending=%h required 0/FF",
               {change, on_off, dev_id, tracked_count}, pending);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < N_DEV; k++) push_ev(k, 1'b1, k + 1);
    cyc = 0;
    while (sb.size() != 0 && cyc < 30) begin
      @(negedge clk); cyc++;
      e = sb.pop_front();
      checks++;
      if ({change, dev_id, on_off, tracked_count} !== {1'b1, e.id, e.on, e.cnt}) begin
        errors++;
        $display("FAIL rerep_event: chg/id/on/cnt=%b/%0d/%b/%0d required 1/%0d/%b/%0d",
                 change, dev_id, on_off, tracked_count, e.id, e.on, e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0 || tracked_count !== 8'd8 || mon_count !== 8) begin
      errors++;
      $display("FAIL rerep_end: change=%b count=%0d monitor=%0d required 0/8/8",
               change, tracked_count, mon_count);
    end
  endtask

  initial begin
    test_reset();
    test_connect_pair();
    test_disconnect();
    test_back_to_back(8'hFF, 1'b1);   // ids 3..7,0,1,2 connect, count 1..8
    test_back_to_back(8'h00, 1'b0);   // ids 3..7,0,1,2 disconnect, count 7..0
    test_net_change();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
